// File: rtl/report_collector_pkg.sv
// Shared types for the cluster-4 report collector: default widths, FSM
// state encoding and the buffered entry layout.
package report_collector_pkg;

  localparam int unsigned NUM_RPT_DEF = 28;
  localparam int unsigned CNT_W_DEF   = 16;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    OVF  = 2'd1,
    MARK = 2'd2
  } rc_state_e;

  typedef struct packed {
    logic                   marker;
    logic [CNT_W_DEF-1:0]   cycle;
    logic [NUM_RPT_DEF-1:0] vec;
  } rc_entry_t;

endpackage

// File: rtl/report_collector_c4_fifo.sv
// rpt_fifo: show-ahead FIFO of rc_entry_t with a registered head entry.
// Callers must only push when there is room (level < DEPTH, or a pop
// happens in the same cycle). The head register is cleared when empty.
module rpt_fifo
  import report_collector_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  rc_entry_t                i_din,
  output logic                     o_valid,
  output rc_entry_t                o_head,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  rc_entry_t        r_mem [DEPTH];
  rc_entry_t        r_head;
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [LW-1:0]    r_level;
  logic             r_valid;

  logic [LW-1:0]    w_level_after_pop;
  logic [LW-1:0]    w_level_nxt;
  logic [AW-1:0]    w_rd_nxt;

  assign w_level_after_pop = r_level - LW'(i_pop);
  assign w_level_nxt       = w_level_after_pop + LW'(i_push);
  assign w_rd_nxt          = r_rd + AW'(i_pop);

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr] <= i_din;
  end

  // Pointers, occupancy and the registered head entry. When the entry that
  // becomes head is being written this same cycle, it bypasses the array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
      r_valid <= 1'b0;
      r_head  <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + AW'(1);
      r_rd    <= w_rd_nxt;
      r_level <= w_level_nxt;
      r_valid <= (w_level_nxt != '0);
      if (w_level_after_pop == '0) begin
        r_head <= i_push ? i_din : '0;
      end else if (i_pop) begin
        r_head <= r_mem[w_rd_nxt];
      end
    end
  end

  assign o_valid = r_valid;
  assign o_head  = r_head;
  assign o_level = r_level;

endmodule

// File: rtl/report_collector_c4.sv
// report_collector_c4: captures the cluster-4 automata report wires each run
// cycle, tags non-zero vectors with the symbol index and streams them out of
// a FIFO over valid/ready. Overflow drops entries until the buffer drains,
// then a single marker entry is enqueued.
// Optional: define RPT_DROP_CNT_EN to add the saturating drop_cnt output.
module report_collector_c4
  import report_collector_pkg::*;
#(
  parameter int unsigned NUM_RPT = NUM_RPT_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned DEPTH   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     run,
  input  logic [NUM_RPT-1:0]       report_vec,
  output logic                     rpt_valid,
  input  logic                     rpt_ready,
  output logic [NUM_RPT-1:0]       rpt_vec,
  output logic [CNT_W-1:0]         rpt_cycle,
  output logic                     rpt_marker,
  output logic                     ovf_sticky,
`ifdef RPT_DROP_CNT_EN
  output logic [15:0]              drop_cnt,
`endif
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic [CNT_W-1:0]   r_sym_cnt;
  logic               r_cap_req;
  logic [NUM_RPT-1:0] r_cap_vec;
  logic [CNT_W-1:0]   r_cap_cycle;
  rc_state_e          r_state;
  logic               r_ovf_sticky;

  logic               w_pop;
  logic               w_can_push;
  logic               w_push;
  logic               w_drop;
  rc_entry_t          w_din;
  rc_entry_t          w_head;
  logic               w_valid;
  logic [LW-1:0]      w_level;

  // Symbol counter and one-cycle capture of the report wires with their tag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sym_cnt   <= '0;
      r_cap_req   <= 1'b0;
      r_cap_vec   <= '0;
      r_cap_cycle <= '0;
    end else begin
      if (run) r_sym_cnt <= r_sym_cnt + CNT_W'(1);
      r_cap_req   <= run && (|report_vec);
      r_cap_vec   <= report_vec;
      r_cap_cycle <= r_sym_cnt;
    end
  end

  assign w_pop      = w_valid && rpt_ready;
  assign w_can_push = (w_level != LW'(DEPTH)) || w_pop;

  // Push arbitration: what gets enqueued this cycle and what gets dropped.
  always_comb begin
    w_push = 1'b0;
    w_drop = 1'b0;
    w_din  = '{marker: 1'b0, cycle: r_cap_cycle, vec: r_cap_vec};
    case (r_state)
      RUN: begin
        w_push = r_cap_req && w_can_push;
        w_drop = r_cap_req && !w_can_push;
      end
      OVF: begin
        w_drop = r_cap_req;
      end
      MARK: begin
        w_push = 1'b1;
        w_din  = '{marker: 1'b1, cycle: r_sym_cnt, vec: '0};
        w_drop = r_cap_req;
      end
      default: begin
        w_push = 1'b0;
        w_drop = r_cap_req;
      end
    endcase
  end

  // Overflow recovery FSM and sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= RUN;
      r_ovf_sticky <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (r_cap_req && !w_can_push) begin
            r_state      <= OVF;
            r_ovf_sticky <= 1'b1;
          end
        end
        OVF: begin
          if (w_level == '0) r_state <= MARK;
        end
        MARK:    r_state <= RUN;
        default: r_state <= RUN;
      endcase
    end
  end

`ifdef RPT_DROP_CNT_EN
  logic [15:0] r_drop_cnt;

  // Saturating count of dropped push requests.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign drop_cnt = r_drop_cnt;
`else
  logic w_unused_drop;
  assign w_unused_drop = w_drop;
`endif

  rpt_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_din),
    .o_valid (w_valid),
    .o_head  (w_head),
    .o_level (w_level)
  );

  assign rpt_valid  = w_valid;
  assign rpt_vec    = w_head.vec;
  assign rpt_cycle  = w_head.cycle;
  assign rpt_marker = w_head.marker;
  assign ovf_sticky = r_ovf_sticky;
  assign fifo_level = w_level;

endmodule

// File: tb/tb_report_collector_c4.sv
// Directed bench for report_collector_c4: a vector table for basic capture
// and tagging, plus hand-written sequences for overflow recovery, full-FIFO
// push/pop, counter wrap and mid-stream reset.
module tb_report_collector_c4;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [27:0] report_vec;
  logic        rpt_valid;
  logic        rpt_ready;
  logic [27:0] rpt_vec;
  logic [15:0] rpt_cycle;
  logic        rpt_marker;
  logic        ovf_sticky;
  logic [3:0]  fifo_level;
`ifdef RPT_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  report_collector_c4 #(
    .NUM_RPT (28),
    .CNT_W   (16),
    .DEPTH   (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .report_vec (report_vec),
    .rpt_valid  (rpt_valid),
    .rpt_ready  (rpt_ready),
    .rpt_vec    (rpt_vec),
    .rpt_cycle  (rpt_cycle),
    .rpt_marker (rpt_marker),
    .ovf_sticky (ovf_sticky),
`ifdef RPT_DROP_CNT_EN
    .drop_cnt   (drop_cnt),
`endif
    .fifo_level (fifo_level)
  );

  typedef struct {
    logic        run;
    logic [27:0] vec;
    logic        ready;
    logic        exp_valid;
    logic [27:0] exp_vec;
    logic [15:0] exp_cycle;
    logic [3:0]  exp_level;
  } row_t;

  row_t tbl[24];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string tag, input logic v, input logic [27:0] hv,
                          input logic [15:0] hc, input logic hm, input logic [3:0] lv);
    chk({tag, ".valid"}, 64'(rpt_valid), 64'(v));
    chk({tag, ".level"}, 64'(fifo_level), 64'(lv));
    if (v) begin
      chk({tag, ".vec"},    64'(rpt_vec),    64'(hv));
      chk({tag, ".cycle"},  64'(rpt_cycle),  64'(hc));
      chk({tag, ".marker"}, 64'(rpt_marker), 64'(hm));
    end
  endtask

  task automatic set_row(input int i, input logic r, input logic [27:0] v, input logic rdy,
                         input logic ev, input logic [27:0] evec, input logic [15:0] ecyc,
                         input logic [3:0] elev);
    tbl[i] = '{run: r, vec: v, ready: rdy, exp_valid: ev, exp_vec: evec,
               exp_cycle: ecyc, exp_level: elev};
  endtask

  // Global time bound so the bench can never hang.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Table: test 1 (report at sym 5) and test 2 (idle symbols, run=0 masking).
    for (int i = 0; i < 5; i++) set_row(i, 1'b1, 28'h0, 1'b1, 1'b0, 28'h0, 16'h0, 4'd0);
    set_row(5, 1'b1, 28'h0000010, 1'b1, 1'b0, 28'h0, 16'h0, 4'd0);
    set_row(6, 1'b0, 28'h0, 1'b1, 1'b1, 28'h0000010, 16'd5, 4'd1);
    set_row(7, 1'b0, 28'h0, 1'b1, 1'b0, 28'h0, 16'h0, 4'd0);
    for (int i = 8; i < 18; i++) set_row(i, 1'b1, 28'h0, 1'b1, 1'b0, 28'h0, 16'h0, 4'd0);
    for (int i = 18; i < 21; i++) set_row(i, 1'b0, 28'hFFFFFFF, 1'b1, 1'b0, 28'h0, 16'h0, 4'd0);
    set_row(21, 1'b1, 28'h0000001, 1'b1, 1'b0, 28'h0, 16'h0, 4'd0);
    set_row(22, 1'b0, 28'h0, 1'b1, 1'b1, 28'h0000001, 16'd16, 4'd1);
    set_row(23, 1'b0, 28'h0, 1'b1, 1'b0, 28'h0, 16'h0, 4'd0);

    reset = 1'b1; run = 1'b0; report_vec = '0; rpt_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk_head("reset", 1'b0, 28'h0, 16'h0, 1'b0, 4'd0);
    chk("reset.vec", 64'(rpt_vec), 64'h0);
    chk("reset.cycle", 64'(rpt_cycle), 64'h0);
    chk("reset.marker", 64'(rpt_marker), 64'h0);
    chk("reset.ovf", 64'(ovf_sticky), 64'h0);
`ifdef RPT_DROP_CNT_EN
    chk("reset.drop", 64'(drop_cnt), 64'h0);
`endif

    for (int i = 0; i < 24; i++) begin
      run = tbl[i].run; report_vec = tbl[i].vec; rpt_ready = tbl[i].ready;
      tick();
      chk_head($sformatf("row%0d", i), tbl[i].exp_valid, tbl[i].exp_vec,
               tbl[i].exp_cycle, 1'b0, tbl[i].exp_level);
    end
    chk("t2.ovf", 64'(ovf_sticky), 64'h0);

    // Test 3: nine reports with the consumer stalled (syms 17..25).
    rpt_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      run = 1'b1; report_vec = 28'(i + 1);
      tick();
    end
    chk_head("t3.full", 1'b1, 28'h1, 16'd17, 1'b0, 4'd8);
    chk("t3.ovf_pre", 64'(ovf_sticky), 64'h0);
    run = 1'b0; report_vec = '0;
    tick();
    chk_head("t3.drop", 1'b1, 28'h1, 16'd17, 1'b0, 4'd8);
    chk("t3.ovf", 64'(ovf_sticky), 64'h1);
`ifdef RPT_DROP_CNT_EN
    chk("t3.drop_cnt", 64'(drop_cnt), 64'd1);
`endif

    // Test 4: drain while reporting; originals, then marker, then capture resumes.
    rpt_ready = 1'b1; run = 1'b1; report_vec = 28'hABC;
    for (int k = 0; k < 8; k++) begin
      chk_head($sformatf("t4.out%0d", k), 1'b1, 28'(k + 1), 16'(17 + k), 1'b0, 4'(8 - k));
      tick();
    end
    chk_head("t4.empty", 1'b0, 28'h0, 16'h0, 1'b0, 4'd0);
    tick();
    chk_head("t4.ovf_wait", 1'b0, 28'h0, 16'h0, 1'b0, 4'd0);
    tick();
    chk_head("t4.marker", 1'b1, 28'h0, 16'd35, 1'b1, 4'd1);
    tick();
    chk_head("t4.resume0", 1'b1, 28'hABC, 16'd35, 1'b0, 4'd1);
    run = 1'b0;
    tick();
    chk_head("t4.resume1", 1'b1, 28'hABC, 16'd36, 1'b0, 4'd1);
    tick();
    chk_head("t4.drained", 1'b0, 28'h0, 16'h0, 1'b0, 4'd0);
    chk("t4.ovf", 64'(ovf_sticky), 64'h1);
`ifdef RPT_DROP_CNT_EN
    chk("t4.drop_cnt", 64'(drop_cnt), 64'd10);
`endif

    // Clean restart for test 5.
    reset = 1'b1; rpt_ready = 1'b0; run = 1'b0; report_vec = '0;
    tick();
    reset = 1'b0;
    chk("rst2.ovf", 64'(ovf_sticky), 64'h0);
    chk_head("rst2", 1'b0, 28'h0, 16'h0, 1'b0, 4'd0);

    // Test 5: full FIFO with simultaneous push and pop (syms 0..8).
    for (int i = 0; i < 9; i++) begin
      run = 1'b1; report_vec = 28'(32'h100 + i);
      tick();
    end
    chk_head("t5.full", 1'b1, 28'h100, 16'd0, 1'b0, 4'd8);
    run = 1'b0; report_vec = '0; rpt_ready = 1'b1;
    tick();
    chk_head("t5.pushpop", 1'b1, 28'h101, 16'd1, 1'b0, 4'd8);
    chk("t5.ovf", 64'(ovf_sticky), 64'h0);
`ifdef RPT_DROP_CNT_EN
    chk("t5.drop_cnt", 64'(drop_cnt), 64'd0);
`endif
    for (int k = 1; k <= 8; k++) begin
      chk_head($sformatf("t5.out%0d", k), 1'b1, 28'(32'h100 + k), 16'(k), 1'b0, 4'(9 - k));
      tick();
    end
    chk_head("t5.empty", 1'b0, 28'h0, 16'h0, 1'b0, 4'd0);

    // Test 6: advance the symbol counter from 9 to 16'hFFFF, report across the wrap.
    rpt_ready = 1'b0; run = 1'b1; report_vec = '0;
    repeat (65526) tick();
    report_vec = 28'h5;
    tick();
    chk_head("t6.cap", 1'b0, 28'h0, 16'h0, 1'b0, 4'd0);
    report_vec = 28'h6;
    tick();
    chk_head("t6.ffff", 1'b1, 28'h5, 16'hFFFF, 1'b0, 4'd1);
    report_vec = 28'h7;
    tick();
    chk_head("t6.l2", 1'b1, 28'h5, 16'hFFFF, 1'b0, 4'd2);
    run = 1'b0; report_vec = '0;
    tick();
    chk_head("t6.l3", 1'b1, 28'h5, 16'hFFFF, 1'b0, 4'd3);
    rpt_ready = 1'b1;
    tick();
    chk_head("t6.wrap", 1'b1, 28'h6, 16'h0000, 1'b0, 4'd2);
    #2 reset = 1'b1;
    #1;
    chk("t6.rst.valid", 64'(rpt_valid), 64'h0);
    chk("t6.rst.level", 64'(fifo_level), 64'h0);
    chk("t6.rst.vec", 64'(rpt_vec), 64'h0);
    #1 reset = 1'b0;
    tick();
    chk_head("t6.after", 1'b0, 28'h0, 16'h0, 1'b0, 4'd0);
    chk("t6.ovf", 64'(ovf_sticky), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
